// File: rtl/mem_access.sv
// Memory-access stage: issues one outstanding req/ack transaction per load or store, with timeout.
// Optional MEM_BYTE_EN adds byte/half/word access via mem_size and dmem_be.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        wb_en_in,
    input  logic [4:0]  dest_in,
    input  logic [31:0] PC_in,
`ifdef MEM_BYTE_EN
    input  logic [1:0]  mem_size,
    output logic [3:0]  dmem_be,
`endif
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        done_out,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        wb_en,
    output logic [31:0] PC_out,
    output logic        mem_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic             done_q, done_d, wb_en_q, wb_en_d, err_q, err_d;
    logic [31:0]      wb_data_q, wb_data_d, pc_q, pc_d;
    logic [4:0]       wb_dest_q, wb_dest_d;
    logic [4:0]       lat_dest_q, lat_dest_d;
    logic             lat_wb_en_q, lat_wb_en_d;
    logic [31:0]      lat_pc_q, lat_pc_d;
    logic             misaligned;
    logic [31:0]      load_val;
`ifdef MEM_BYTE_EN
    logic [3:0]       be_q, be_d;
    logic [1:0]       lat_lo_q, lat_lo_d, lat_size_q, lat_size_d;
    logic [31:0]      rshift;
`endif

`ifdef MEM_BYTE_EN
    always_comb begin
        case (mem_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = alu_result[0];
            default: misaligned = (alu_result[1:0] != 2'b00);
        endcase
        // Lanes are little-endian: byte 0 of the word sits in rdata[7:0].
        rshift = dmem_rdata >> {lat_lo_q, 3'b000};
        case (lat_size_q)
            2'd0:    load_val = {{24{rshift[7]}}, rshift[7:0]};
            2'd1:    load_val = {{16{rshift[15]}}, rshift[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end
`else
    assign misaligned = (alu_result[1:0] != 2'b00);
    assign load_val   = dmem_rdata;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        wb_en_d     = wb_en_q;
        err_d       = err_q;
        wb_data_d   = wb_data_q;
        wb_dest_d   = wb_dest_q;
        pc_d        = pc_q;
        lat_dest_d  = lat_dest_q;
        lat_wb_en_d = lat_wb_en_q;
        lat_pc_d    = lat_pc_q;
`ifdef MEM_BYTE_EN
        be_d        = be_q;
        lat_lo_d    = lat_lo_q;
        lat_size_d  = lat_size_q;
`endif
        if (state_q == S_IDLE) begin
            if (done_in && !is_load && !is_store) begin
                done_d    = 1'b1;
                wb_data_d = alu_result;
                wb_dest_d = dest_in;
                wb_en_d   = wb_en_in;
                pc_d      = PC_in;
                err_d     = 1'b0;
            end else if (done_in && misaligned) begin
                done_d  = 1'b1;
                wb_en_d = 1'b0;
                err_d   = 1'b1;
                pc_d    = PC_in;
            end else if (done_in) begin
                state_d     = S_BUSY;
                req_d       = 1'b1;
                we_d        = is_store;
                cnt_d       = '0;
                lat_dest_d  = dest_in;
                lat_wb_en_d = wb_en_in;
                lat_pc_d    = PC_in;
`ifdef MEM_BYTE_EN
                addr_d     = {alu_result[31:2], 2'b00};
                lat_lo_d   = alu_result[1:0];
                lat_size_d = mem_size;
                case (mem_size)
                    2'd0: begin
                        be_d    = 4'b0001 << alu_result[1:0];
                        wdata_d = {4{store_data[7:0]}};
                    end
                    2'd1: begin
                        be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{store_data[15:0]}};
                    end
                    default: begin
                        be_d    = 4'b1111;
                        wdata_d = store_data;
                    end
                endcase
`else
                addr_d  = alu_result;
                wdata_d = store_data;
`endif
            end
        end else begin
            if (dmem_ack) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b0;
                pc_d    = lat_pc_q;
                if (we_q) begin
                    wb_en_d = 1'b0;
                end else begin
                    wb_data_d = load_val;
                    wb_en_d   = lat_wb_en_q;
                    wb_dest_d = lat_dest_q;
                end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                done_d  = 1'b1;
                wb_en_d = 1'b0;
                err_d   = 1'b1;
                pc_d    = lat_pc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            err_q       <= 1'b0;
            wb_data_q   <= '0;
            wb_dest_q   <= '0;
            pc_q        <= '0;
            lat_dest_q  <= '0;
            lat_wb_en_q <= 1'b0;
            lat_pc_q    <= '0;
`ifdef MEM_BYTE_EN
            be_q        <= '0;
            lat_lo_q    <= '0;
            lat_size_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            wb_en_q     <= wb_en_d;
            err_q       <= err_d;
            wb_data_q   <= wb_data_d;
            wb_dest_q   <= wb_dest_d;
            pc_q        <= pc_d;
            lat_dest_q  <= lat_dest_d;
            lat_wb_en_q <= lat_wb_en_d;
            lat_pc_q    <= lat_pc_d;
`ifdef MEM_BYTE_EN
            be_q        <= be_d;
            lat_lo_q    <= lat_lo_d;
            lat_size_q  <= lat_size_d;
`endif
        end
    end

    assign stall_out  = (state_q == S_BUSY);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign done_out   = done_q;
    assign wb_data    = wb_data_q;
    assign wb_dest    = wb_dest_q;
    assign wb_en      = wb_en_q;
    assign PC_out     = pc_q;
    assign mem_err    = err_q;
`ifdef MEM_BYTE_EN
    assign dmem_be    = be_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (default build, word accesses only).
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        done_in, is_load, is_store, wb_en_in, dmem_ack;
    logic [31:0] alu_result, store_data, PC_in, dmem_rdata;
    logic [4:0]  dest_in;
    logic        stall_out, dmem_req, dmem_we, done_out, wb_en, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data, PC_out;
    logic [4:0]  wb_dest;
    int          vectors = 0;
    int          miscompares = 0;

    mem_access #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .done_in(done_in), .alu_result(alu_result),
        .store_data(store_data), .is_load(is_load), .is_store(is_store),
        .wb_en_in(wb_en_in), .dest_in(dest_in), .PC_in(PC_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .done_out(done_out), .wb_data(wb_data),
        .wb_dest(wb_dest), .wb_en(wb_en), .PC_out(PC_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        done_in = 0; is_load = 0; is_store = 0; wb_en_in = 0; dmem_ack = 0;
        alu_result = 0; store_data = 0; PC_in = 0; dmem_rdata = 0; dest_in = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        step(); step();
        vectors++;
        if ({stall_out, dmem_req, dmem_we, done_out, wb_en, mem_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {stall_out, dmem_req, dmem_we, done_out, wb_en, mem_err});
        end
        vectors++;
        if ({dmem_addr, dmem_wdata, wb_data, PC_out, wb_dest} !== 133'b0) begin
            miscompares++;
            $display("FAIL reset_data addr=%h wdata=%h wb_data=%h pc=%h dest=%0d want all 0",
                     dmem_addr, dmem_wdata, wb_data, PC_out, wb_dest);
        end
        rst = 1;
        step();
    endtask

    task automatic test_pass_through();
        done_in = 1; alu_result = 32'h0000_00FF; dest_in = 5; wb_en_in = 1; PC_in = 32'h10;
        step();
        done_in = 0;
        vectors++;
        if ({done_out, wb_en, mem_err, stall_out} !== 4'b1100) begin
            miscompares++;
            $display("FAIL pass_flags got=%b want=1100", {done_out, wb_en, mem_err, stall_out});
        end
        vectors++;
        if (wb_data !== 32'hFF || wb_dest !== 5'd5 || PC_out !== 32'h10) begin
            miscompares++;
            $display("FAIL pass_data wb_data=%h dest=%0d pc=%h want ff/5/10", wb_data, wb_dest, PC_out);
        end
        step();
        vectors++;
        if (done_out !== 1'b0 || wb_data !== 32'hFF) begin
            miscompares++;
            $display("FAIL idle_hold done=%b wb_data=%h want 0/ff", done_out, wb_data);
        end
    endtask

    task automatic test_load_slow();
        done_in = 1; is_load = 1; alu_result = 32'h100; dest_in = 7; wb_en_in = 1; PC_in = 32'h40;
        for (int c = 1; c <= 3; c++) begin
            step();
            done_in = 0; is_load = 0; alu_result = 32'hFFFF_FFF0;
            if (c == 3) begin dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF; end
            vectors++;
            if ({stall_out, dmem_req, dmem_we, done_out} !== 4'b1100 || dmem_addr !== 32'h100) begin
                miscompares++;
                $display("FAIL load_busy_c%0d flags=%b addr=%h want 1100/100",
                         c, {stall_out, dmem_req, dmem_we, done_out}, dmem_addr);
            end
        end
        step();
        dmem_ack = 0; dmem_rdata = 0;
        vectors++;
        if ({done_out, wb_en, mem_err, dmem_req, stall_out} !== 5'b11000) begin
            miscompares++;
            $display("FAIL load_done flags=%b want=11000", {done_out, wb_en, mem_err, dmem_req, stall_out});
        end
        vectors++;
        if (wb_data !== 32'hDEAD_BEEF || wb_dest !== 5'd7 || PC_out !== 32'h40) begin
            miscompares++;
            $display("FAIL load_data wb_data=%h dest=%0d pc=%h want deadbeef/7/40", wb_data, wb_dest, PC_out);
        end
        step();
    endtask

    task automatic test_store();
        done_in = 1; is_store = 1; alu_result = 32'h204; store_data = 32'h1234_5678;
        wb_en_in = 1; dest_in = 9; PC_in = 32'h50;
        step();
        done_in = 0; is_store = 0; store_data = 0; dmem_ack = 1;
        vectors++;
        if ({dmem_req, dmem_we} !== 2'b11 || dmem_addr !== 32'h204 || dmem_wdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL store_req req/we=%b addr=%h wdata=%h want 11/204/12345678",
                     {dmem_req, dmem_we}, dmem_addr, dmem_wdata);
        end
        step();
        dmem_ack = 0;
        vectors++;
        if ({done_out, wb_en, mem_err} !== 3'b100 || PC_out !== 32'h50) begin
            miscompares++;
            $display("FAIL store_done flags=%b pc=%h want 100/50", {done_out, wb_en, mem_err}, PC_out);
        end
        step();
    endtask

    task automatic test_misaligned();
        done_in = 1; is_load = 1; alu_result = 32'h102; wb_en_in = 1; PC_in = 32'h88;
        step();
        done_in = 0; is_load = 0;
        vectors++;
        if ({dmem_req, done_out, mem_err, wb_en, stall_out} !== 5'b01100 || PC_out !== 32'h88) begin
            miscompares++;
            $display("FAIL misaligned flags=%b pc=%h want 01100/88",
                     {dmem_req, done_out, mem_err, wb_en, stall_out}, PC_out);
        end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        done_in = 1; is_load = 1; alu_result = 32'h300; wb_en_in = 1; PC_in = 32'h60;
        step();
        done_in = 0; is_load = 0;
        while (dmem_req && n < 40) begin
            n++;
            step();
        end
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL timeout_req_cycles got=%0d want=16", n);
        end
        vectors++;
        if ({done_out, mem_err, wb_en, stall_out} !== 4'b1100 || PC_out !== 32'h60) begin
            miscompares++;
            $display("FAIL timeout_done flags=%b pc=%h want 1100/60", {done_out, mem_err, wb_en, stall_out}, PC_out);
        end
        step();
        dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
        step();
        dmem_ack = 0;
        vectors++;
        if (done_out !== 1'b0 || stall_out !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack done=%b stall=%b want 0/0", done_out, stall_out);
        end
        step();
    endtask

    task automatic test_reset_busy();
        done_in = 1; is_load = 1; alu_result = 32'h400; wb_en_in = 1; PC_in = 32'h70;
        step();
        done_in = 0; is_load = 0;
        rst = 0;
        step();
        rst = 1;
        vectors++;
        if ({dmem_req, stall_out, done_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_busy flags=%b want=000", {dmem_req, stall_out, done_out});
        end
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        vectors++;
        if (done_out !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_ack done=%b req=%b want 0/0", done_out, dmem_req);
        end
        step();
    endtask

    task automatic test_back_to_back();
        done_in = 1; alu_result = 32'hA1; dest_in = 3; wb_en_in = 1; PC_in = 32'h80;
        step();
        alu_result = 32'hB2; dest_in = 4; wb_en_in = 0; PC_in = 32'h84;
        vectors++;
        if (done_out !== 1'b1 || wb_data !== 32'hA1 || wb_dest !== 5'd3 || wb_en !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first done=%b wb_data=%h dest=%0d en=%b want 1/a1/3/1",
                     done_out, wb_data, wb_dest, wb_en);
        end
        step();
        done_in = 0;
        vectors++;
        if (done_out !== 1'b1 || wb_data !== 32'hB2 || wb_dest !== 5'd4 || wb_en !== 1'b0 || PC_out !== 32'h84) begin
            miscompares++;
            $display("FAIL b2b_second done=%b wb_data=%h dest=%0d en=%b pc=%h want 1/b2/4/0/84",
                     done_out, wb_data, wb_dest, wb_en, PC_out);
        end
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        vectors++;
        if ({done_out, dmem_req, stall_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_ack flags=%b want=000", {done_out, dmem_req, stall_out});
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_slow();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
